// File: rtl/assert_fail_logger.sv
// Assertion failure logger: qualifies per-checker failure pulses, timestamps them
// into a first-word-fall-through log FIFO, and keeps saturating failure/drop counters.
module assert_fail_logger #(
  parameter int NUM_CHK = 4,
  parameter int DEPTH   = 8,
  parameter int TS_W    = 16,
  parameter int CNT_W   = 16,
  localparam int IDW    = $clog2(NUM_CHK)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               disable_iff,
  input  logic               clr,
  input  logic [NUM_CHK-1:0] fail,
  output logic               log_valid,
  input  logic               log_ready,
  output logic [IDW-1:0]     log_id,
  output logic               log_multi,
  output logic [TS_W-1:0]    log_ts,
  output logic [CNT_W-1:0]   fail_cnt,
  output logic [CNT_W-1:0]   drop_cnt,
  output logic               overflow
);

  localparam int AW  = $clog2(DEPTH);
  localparam int PCW = $clog2(NUM_CHK + 1);
  localparam int SW  = ((CNT_W > PCW) ? CNT_W : PCW) + 1;

  typedef struct packed {
    logic [IDW-1:0]  id;
    logic            multi;
    logic [TS_W-1:0] ts;
  } entry_t;

  entry_t           mem [DEPTH];
  entry_t           head;
  logic [AW:0]      wr_ptr, rd_ptr;
  logic [TS_W-1:0]  ts;
  logic [NUM_CHK-1:0] qual;
  logic [IDW-1:0]   low_id;
  logic             found;
  logic [PCW-1:0]   pc;
  logic [SW-1:0]    fail_sum;
  logic             empty, full, push, pop, wr_en, drop;

  // Failures arriving during a soft clear are discarded along with the log.
  assign qual = fail & {NUM_CHK{~disable_iff & ~clr}};

  always_comb begin
    low_id = '0;
    found  = 1'b0;
    pc     = '0;
    for (int unsigned i = 0; i < NUM_CHK; i++) begin
      pc = pc + PCW'(qual[i]);
      if (qual[i] && !found) begin
        low_id = IDW'(i);
        found  = 1'b1;
      end
    end
  end

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push     = found;
  assign pop      = log_valid && log_ready;
  assign wr_en    = push && (!full || pop);
  assign drop     = push && full && !pop;
  assign fail_sum = SW'(fail_cnt) + SW'(pc);

  assign head      = mem[rd_ptr[AW-1:0]];
  assign log_valid = !empty;
  // Head fields read as zero while empty so the port values match reset until the first push.
  assign log_id    = empty ? '0 : head.id;
  assign log_multi = empty ? 1'b0 : head.multi;
  assign log_ts    = empty ? '0 : head.ts;

  always_ff @(posedge clk) begin
    if (rst) ts <= '0;
    else     ts <= ts + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      mem[wr_ptr[AW-1:0]] <= '{id: low_id, multi: (pc > PCW'(1)), ts: ts};
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fail_cnt <= '0;
      drop_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      if (fail_sum[SW-1:CNT_W] != '0) fail_cnt <= '1;
      else                            fail_cnt <= fail_sum[CNT_W-1:0];
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_assert_fail_logger.sv
// Directed bench for assert_fail_logger: a default build plus a narrow-counter,
// narrow-timestamp build driven by the same inputs.
module tb_assert_fail_logger;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        disable_iff = 1'b0;
  logic        clr = 1'b0;
  logic [3:0]  fail = '0;
  logic        log_ready = 1'b0;

  logic        log_valid, log_multi, overflow;
  logic [1:0]  log_id;
  logic [15:0] log_ts, fail_cnt, drop_cnt;

  logic        s_valid, s_multi, s_overflow;
  logic [1:0]  s_id;
  logic [3:0]  s_ts, s_fail_cnt, s_drop_cnt;

  int nvec = 0;
  int nerr = 0;
  int ts_now = 0;

  always #5 clk = ~clk;

  assert_fail_logger #(.NUM_CHK(4), .DEPTH(8), .TS_W(16), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .disable_iff(disable_iff), .clr(clr), .fail(fail),
    .log_valid(log_valid), .log_ready(log_ready), .log_id(log_id),
    .log_multi(log_multi), .log_ts(log_ts), .fail_cnt(fail_cnt),
    .drop_cnt(drop_cnt), .overflow(overflow)
  );

  assert_fail_logger #(.NUM_CHK(4), .DEPTH(8), .TS_W(4), .CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .disable_iff(disable_iff), .clr(clr), .fail(fail),
    .log_valid(s_valid), .log_ready(log_ready), .log_id(s_id),
    .log_multi(s_multi), .log_ts(s_ts), .fail_cnt(s_fail_cnt),
    .drop_cnt(s_drop_cnt), .overflow(s_overflow)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    ts_now++;
  endtask

  task automatic do_reset();
    rst = 1'b1; fail = '0; clr = 1'b0; disable_iff = 1'b0; log_ready = 1'b0;
    tick();
    rst = 1'b0;
    ts_now = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1; fail = 4'b1111; clr = 1'b1; disable_iff = 1'b0; log_ready = 1'b1;
    tick();
    rst = 1'b0; fail = '0; clr = 1'b0; log_ready = 1'b0; ts_now = 0;
    nvec++; if ({log_valid, log_id, log_multi, log_ts} !== 20'h0) begin nerr++;
      $display("FAIL reset_log: got %0h expected 0", {log_valid, log_id, log_multi, log_ts}); end
    nvec++; if ({fail_cnt, drop_cnt, overflow} !== 33'h0) begin nerr++;
      $display("FAIL reset_cnt: got %0h expected 0", {fail_cnt, drop_cnt, overflow}); end
    nvec++; if ({s_valid, s_id, s_multi, s_ts, s_fail_cnt, s_drop_cnt, s_overflow} !== 17'h0) begin nerr++;
      $display("FAIL reset_sat: got %0h expected 0", {s_valid, s_id, s_multi, s_ts, s_fail_cnt, s_drop_cnt, s_overflow}); end
    tick();
    nvec++; if ({log_valid, log_ts, fail_cnt} !== 33'h0) begin nerr++;
      $display("FAIL reset_hold: got %0h expected 0", {log_valid, log_ts, fail_cnt}); end
  endtask

  task automatic test_multi();
    do_reset();
    repeat (5) tick();
    fail = 4'b0110;
    tick();
    fail = '0;
    nvec++; if (log_valid !== 1'b1) begin nerr++; $display("FAIL multi_valid: got %0b expected 1", log_valid); end
    nvec++; if (log_id !== 2'd1) begin nerr++; $display("FAIL multi_id: got %0d expected 1", log_id); end
    nvec++; if (log_multi !== 1'b1) begin nerr++; $display("FAIL multi_flag: got %0b expected 1", log_multi); end
    nvec++; if (log_ts !== 16'd5) begin nerr++; $display("FAIL multi_ts: got %0d expected 5", log_ts); end
    nvec++; if (fail_cnt !== 16'd2) begin nerr++; $display("FAIL multi_cnt: got %0d expected 2", fail_cnt); end
  endtask

  task automatic test_disable();
    do_reset();
    disable_iff = 1'b1; fail = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      tick();
      nvec++; if (log_valid !== 1'b0) begin nerr++; $display("FAIL disable_valid: got %0b expected 0", log_valid); end
    end
    disable_iff = 1'b0; fail = '0;
    nvec++; if (fail_cnt !== 16'd0) begin nerr++; $display("FAIL disable_cnt: got %0d expected 0", fail_cnt); end
  endtask

  task automatic test_overflow();
    logic [1:0]  exp_id [10];
    logic [15:0] exp_ts [10];
    logic [3:0]  one = 4'b0001;
    do_reset();
    for (int k = 0; k < 10; k++) begin
      fail = one << (k % 4);
      exp_id[k] = 2'(k % 4);
      exp_ts[k] = 16'(ts_now);
      tick();
    end
    fail = '0;
    nvec++; if (drop_cnt !== 16'd2) begin nerr++; $display("FAIL ovf_drop: got %0d expected 2", drop_cnt); end
    nvec++; if (overflow !== 1'b1) begin nerr++; $display("FAIL ovf_flag: got %0b expected 1", overflow); end
    nvec++; if (fail_cnt !== 16'd10) begin nerr++; $display("FAIL ovf_cnt: got %0d expected 10", fail_cnt); end
    tick();
    nvec++; if (log_id !== exp_id[0] || log_ts !== exp_ts[0]) begin nerr++;
      $display("FAIL ovf_hold: got id %0d ts %0d expected id %0d ts %0d", log_id, log_ts, exp_id[0], exp_ts[0]); end
    log_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      nvec++; if (log_valid !== 1'b1 || log_id !== exp_id[k] || log_ts !== exp_ts[k] || log_multi !== 1'b0) begin nerr++;
        $display("FAIL ovf_entry%0d: got v%0b id %0d ts %0d m%0b expected v1 id %0d ts %0d m0",
                 k, log_valid, log_id, log_ts, log_multi, exp_id[k], exp_ts[k]); end
      tick();
    end
    nvec++; if (log_valid !== 1'b0) begin nerr++; $display("FAIL ovf_empty: got %0b expected 0", log_valid); end
    log_ready = 1'b0;
  endtask

  task automatic test_full_pushpop();
    logic [1:0]  exp_id [9];
    logic [15:0] exp_ts [9];
    logic [3:0]  one = 4'b0001;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      fail = one << ((k + 1) % 4);
      exp_id[k] = 2'((k + 1) % 4);
      exp_ts[k] = 16'(ts_now);
      tick();
    end
    fail = 4'b0001; log_ready = 1'b1;
    exp_id[8] = 2'd0;
    exp_ts[8] = 16'(ts_now);
    tick();
    fail = '0;
    nvec++; if (drop_cnt !== 16'd0 || overflow !== 1'b0) begin nerr++;
      $display("FAIL fullpp_drop: got %0d/%0b expected 0/0", drop_cnt, overflow); end
    nvec++; if (fail_cnt !== 16'd9) begin nerr++; $display("FAIL fullpp_cnt: got %0d expected 9", fail_cnt); end
    for (int k = 1; k < 9; k++) begin
      nvec++; if (log_valid !== 1'b1 || log_id !== exp_id[k] || log_ts !== exp_ts[k]) begin nerr++;
        $display("FAIL fullpp_entry%0d: got v%0b id %0d ts %0d expected v1 id %0d ts %0d",
                 k, log_valid, log_id, log_ts, exp_id[k], exp_ts[k]); end
      tick();
    end
    nvec++; if (log_valid !== 1'b0) begin nerr++; $display("FAIL fullpp_empty: got %0b expected 0", log_valid); end
    log_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [15:0] ta, tb;
    do_reset();
    log_ready = 1'b1;
    fail = 4'b1000; ta = 16'(ts_now);
    tick();
    nvec++; if (log_valid !== 1'b1 || log_id !== 2'd3 || log_ts !== ta) begin nerr++;
      $display("FAIL b2b_first: got v%0b id %0d ts %0d expected v1 id 3 ts %0d", log_valid, log_id, log_ts, ta); end
    fail = 4'b0010; tb = 16'(ts_now);
    tick();
    fail = '0;
    nvec++; if (log_valid !== 1'b1 || log_id !== 2'd1 || log_ts !== tb) begin nerr++;
      $display("FAIL b2b_second: got v%0b id %0d ts %0d expected v1 id 1 ts %0d", log_valid, log_id, log_ts, tb); end
    nvec++; if (fail_cnt !== 16'd2) begin nerr++; $display("FAIL b2b_cnt: got %0d expected 2", fail_cnt); end
    tick();
    nvec++; if (log_valid !== 1'b0) begin nerr++; $display("FAIL b2b_empty: got %0b expected 0", log_valid); end
    log_ready = 1'b0;
  endtask

  task automatic test_saturate();
    do_reset();
    fail = 4'b0011;
    repeat (20) tick();
    fail = '0;
    nvec++; if (s_fail_cnt !== 4'd15) begin nerr++; $display("FAIL sat_cnt: got %0d expected 15", s_fail_cnt); end
    nvec++; if (fail_cnt !== 16'd40) begin nerr++; $display("FAIL sat_widecnt: got %0d expected 40", fail_cnt); end
    nvec++; if (s_drop_cnt !== 4'd12 || s_overflow !== 1'b1) begin nerr++;
      $display("FAIL sat_drop: got %0d/%0b expected 12/1", s_drop_cnt, s_overflow); end
    clr = 1'b1; fail = 4'b1111;
    tick();
    clr = 1'b0; fail = '0;
    nvec++; if ({fail_cnt, drop_cnt, overflow, log_valid} !== 34'h0) begin nerr++;
      $display("FAIL clr_state: got %0h expected 0", {fail_cnt, drop_cnt, overflow, log_valid}); end
    nvec++; if ({s_fail_cnt, s_drop_cnt, s_overflow, s_valid} !== 10'h0) begin nerr++;
      $display("FAIL clr_sat: got %0h expected 0", {s_fail_cnt, s_drop_cnt, s_overflow, s_valid}); end
    tick();
    nvec++; if (fail_cnt !== 16'd0 || log_valid !== 1'b0) begin nerr++;
      $display("FAIL clr_after: got cnt %0d v%0b expected 0 v0", fail_cnt, log_valid); end
  endtask

  task automatic test_ts_wrap();
    do_reset();
    repeat (16) tick();
    fail = 4'b0001;
    tick();
    fail = '0;
    nvec++; if (log_ts !== 16'd16) begin nerr++; $display("FAIL wrap_wide: got %0d expected 16", log_ts); end
    nvec++; if (s_ts !== 4'd0 || s_valid !== 1'b1) begin nerr++;
      $display("FAIL wrap_narrow: got ts %0d v%0b expected 0 v1", s_ts, s_valid); end
  endtask

  task automatic test_rst_mid();
    do_reset();
    fail = 4'b0001;
    repeat (3) tick();
    fail = '0;
    nvec++; if (log_valid !== 1'b1) begin nerr++; $display("FAIL rstmid_pre: got %0b expected 1", log_valid); end
    rst = 1'b1; log_ready = 1'b1; fail = 4'b1111;
    tick();
    rst = 1'b0; fail = '0; ts_now = 0;
    nvec++; if (log_valid !== 1'b0 || fail_cnt !== 16'd0) begin nerr++;
      $display("FAIL rstmid_flush: got v%0b cnt %0d expected v0 cnt 0", log_valid, fail_cnt); end
    log_ready = 1'b0;
    fail = 4'b0100;
    tick();
    fail = '0;
    nvec++; if (log_valid !== 1'b1 || log_id !== 2'd2 || log_ts !== 16'd0 || log_multi !== 1'b0) begin nerr++;
      $display("FAIL rstmid_ts0: got v%0b id %0d ts %0d m%0b expected v1 id 2 ts 0 m0",
               log_valid, log_id, log_ts, log_multi); end
  endtask

  initial begin
    test_reset();
    test_multi();
    test_disable();
    test_overflow();
    test_full_pushpop();
    test_back_to_back();
    test_saturate();
    test_ts_wrap();
    test_rst_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
